// File: rtl/main_memory_ctrl_if.sv
// Cache-to-main-memory request/response bus.
// The master is the cache side and the slave is main_memory_ctrl.
interface main_memory_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_busy;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_rlast;
  logic              mem_wack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_busy, mem_rvalid, mem_rdata, mem_rlast, mem_wack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_busy, mem_rvalid, mem_rdata, mem_rlast, mem_wack
  );
endinterface

// File: rtl/main_memory_ctrl.sv
// Main memory controller: fixed-latency block-read bursts and write-through word writes.
// Define MAIN_MEM_STATS_EN to add saturating rd_count/wr_count statistics ports.
module main_memory_ctrl #(
  parameter int DATA_W          = 32,
  parameter int ADDR_W          = 10,
  parameter int WORDS_PER_BLOCK = 4,
  parameter int LATENCY         = 4
) (
  input  logic clk,
  input  logic reset,
  main_memory_ctrl_if.slave bus
`ifdef MAIN_MEM_STATS_EN
  ,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
`endif
);
  localparam int WORD_W = ADDR_W - 2;
  localparam int DEPTH  = 2 ** WORD_W;
  localparam int OFF_W  = $clog2(WORDS_PER_BLOCK);
  localparam int LAT_W  = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'((LATENCY >= 2) ? LATENCY - 2 : 0);
  localparam logic [OFF_W-1:0] OFF_LAST = OFF_W'(WORDS_PER_BLOCK - 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] WAIT    = 2'd1;
  localparam logic [1:0] BURST   = 2'd2;
  localparam logic [1:0] WCOMMIT = 2'd3;

  logic [1:0]        state;
  logic [LAT_W-1:0]  lat_cnt;
  logic [OFF_W-1:0]  off;
  logic [WORD_W-1:0] word_q;
  logic [DATA_W-1:0] wdata_q;
  logic              is_write;
  logic [WORD_W-1:0] burst_idx;
  logic              unused_addr_bits;

  // Contents start at zero and survive reset, so the array has no reset branch.
  logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

  assign burst_idx        = {word_q[WORD_W-1:OFF_W], off};
  assign bus.mem_busy     = (state != IDLE);
  assign unused_addr_bits = ^bus.mem_addr[1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      lat_cnt        <= '0;
      off            <= '0;
      word_q         <= '0;
      wdata_q        <= '0;
      is_write       <= 1'b0;
      bus.mem_rvalid <= 1'b0;
      bus.mem_rlast  <= 1'b0;
      bus.mem_wack   <= 1'b0;
      bus.mem_rdata  <= '0;
    end else begin
      bus.mem_wack <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.mem_req) begin
            word_q   <= bus.mem_addr[ADDR_W-1:2];
            wdata_q  <= bus.mem_wdata;
            is_write <= bus.mem_we;
            lat_cnt  <= '0;
            off      <= '0;
            if (LATENCY == 1) state <= bus.mem_we ? WCOMMIT : BURST;
            else              state <= WAIT;
          end
        end
        WAIT: begin
          if (lat_cnt == LAT_LAST) state <= is_write ? WCOMMIT : BURST;
          else                     lat_cnt <= lat_cnt + 1'b1;
        end
        BURST: begin
          // The cycle after the rlast word ends the burst; rdata keeps the last word.
          if (bus.mem_rlast) begin
            bus.mem_rvalid <= 1'b0;
            bus.mem_rlast  <= 1'b0;
            state          <= IDLE;
          end else begin
            bus.mem_rvalid <= 1'b1;
            bus.mem_rdata  <= mem[burst_idx];
            bus.mem_rlast  <= (off == OFF_LAST);
            off            <= off + 1'b1;
          end
        end
        WCOMMIT: begin
          bus.mem_wack <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Reset drops the FSM out of WCOMMIT asynchronously, so an aborted write never lands.
  always_ff @(posedge clk) begin
    if (state == WCOMMIT) mem[word_q] <= wdata_q;
  end

`ifdef MAIN_MEM_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      if (state == BURST && !bus.mem_rlast && off == OFF_LAST && rd_count != 16'hFFFF)
        rd_count <= rd_count + 16'd1;
      if (state == WCOMMIT && wr_count != 16'hFFFF)
        wr_count <= wr_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_main_memory_ctrl.sv
// Self-checking bench for main_memory_ctrl: directed scenarios plus random traffic
// checked against an array model of the backing store and the burst/write timing rules.
module tb_main_memory_ctrl;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 10;
  localparam int WPB    = 4;
  localparam int LAT    = 4;
  localparam int DEPTH  = 256;

  logic clk;
  logic reset;
  int   checks   = 0;
  int   failures = 0;
  int   exp_rd   = 0;
  int   exp_wr   = 0;
  logic [DATA_W-1:0] model [DEPTH];

  main_memory_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

`ifdef MAIN_MEM_STATS_EN
  logic [15:0] rd_count;
  logic [15:0] wr_count;
`endif

  main_memory_ctrl #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .WORDS_PER_BLOCK(WPB), .LATENCY(LAT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
`ifdef MAIN_MEM_STATS_EN
    ,
    .rd_count(rd_count),
    .wr_count(wr_count)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"},   32'(bus.mem_busy),   32'd0);
    check({tag, "_rvalid"}, 32'(bus.mem_rvalid), 32'd0);
    check({tag, "_rlast"},  32'(bus.mem_rlast),  32'd0);
    check({tag, "_wack"},   32'(bus.mem_wack),   32'd0);
  endtask

  // Reset pulse placed mid-cycle; the outputs must clear before the next clock edge.
  task automatic pulse_reset(input string tag);
    #1 reset = 1'b1;
    #1;
    check_quiet(tag);
    check({tag, "_rdata"}, bus.mem_rdata, 32'd0);
`ifdef MAIN_MEM_STATS_EN
    check({tag, "_rd_count"}, 32'(rd_count), 32'd0);
    check({tag, "_wr_count"}, 32'(wr_count), 32'd0);
`endif
    #1 reset = 1'b0;
    exp_rd = 0;
    exp_wr = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.mem_busy !== 1'b0 && n < 50) begin
      step();
      n++;
    end
    if (n == 50) check("idle_timeout", 32'(bus.mem_busy), 32'd0);
  endtask

  task automatic do_write(input logic [9:0] addr, input logic [31:0] data, input int abort_at);
    wait_idle();
    bus.mem_req   = 1'b1;
    bus.mem_we    = 1'b1;
    bus.mem_addr  = addr;
    bus.mem_wdata = data;
    step();
    bus.mem_req   = 1'b0;
    bus.mem_addr  = 10'($urandom);
    bus.mem_wdata = $urandom;
    check("wr_busy_accept", 32'(bus.mem_busy), 32'd1);
    for (int k = 1; k < LAT; k++) begin
      step();
      check("wr_busy_wait", 32'(bus.mem_busy), 32'd1);
      check("wr_wack_early", 32'(bus.mem_wack), 32'd0);
      if (k == abort_at) begin
        pulse_reset("wr_abort");
        return;
      end
    end
    step();
    check("wr_wack", 32'(bus.mem_wack), 32'd1);
    check("wr_busy_done", 32'(bus.mem_busy), 32'd0);
    check("wr_rvalid", 32'(bus.mem_rvalid), 32'd0);
    model[addr[9:2]] = data;
    exp_wr++;
    step();
    check("wr_wack_pulse", 32'(bus.mem_wack), 32'd0);
  endtask

  task automatic do_read(input logic [9:0] addr, input bit intrude, input int abort_after);
    int base;
    base = (int'(addr) >> 2) & ~(WPB - 1);
    wait_idle();
    bus.mem_req   = 1'b1;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = addr;
    bus.mem_wdata = $urandom;
    step();
    bus.mem_req   = 1'b0;
    bus.mem_addr  = 10'($urandom);
    check("rd_busy_accept", 32'(bus.mem_busy), 32'd1);
    for (int k = 1; k < LAT; k++) begin
      step();
      check("rd_rvalid_early", 32'(bus.mem_rvalid), 32'd0);
      check("rd_busy_wait", 32'(bus.mem_busy), 32'd1);
    end
    for (int i = 0; i < WPB; i++) begin
      if (intrude && i == 0) begin
        bus.mem_req   = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = 10'h000;
        bus.mem_wdata = 32'h1111_1111;
      end
      step();
      check("rd_rvalid", 32'(bus.mem_rvalid), 32'd1);
      check("rd_rdata", bus.mem_rdata, model[base + i]);
      check("rd_rlast", 32'(bus.mem_rlast), (i == WPB - 1) ? 32'd1 : 32'd0);
      check("rd_busy_burst", 32'(bus.mem_busy), 32'd1);
      check("rd_wack", 32'(bus.mem_wack), 32'd0);
      if (intrude && i == WPB - 1) bus.mem_req = 1'b0;
      if (i == abort_after) begin
        pulse_reset("rd_abort");
        return;
      end
    end
    step();
    check_quiet("rd_done");
    check("rd_rdata_hold", bus.mem_rdata, model[base + WPB - 1]);
    exp_rd++;
  endtask

  initial begin
    logic [31:0] a_words [WPB];
    logic [9:0]  raddr;

    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    reset         = 1'b0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    #2 reset = 1'b1;
    repeat (2) step();
    check_quiet("reset");
    check("reset_rdata", bus.mem_rdata, 32'd0);
    reset = 1'b0;
    step();
    check_quiet("post_reset");

    $display("[TB] block read with burst timing");
    for (int i = 0; i < WPB; i++) begin
      a_words[i] = $urandom;
      do_write(10'h040 + 10'(4 * i), a_words[i], -1);
    end
    do_read(10'h048, 1'b0, -1);

    $display("[TB] write at top of array, then block read");
    do_write(10'h3FE, 32'hDEAD_BEEF, -1);
    do_read(10'h3F0, 1'b0, -1);

    $display("[TB] request during burst is ignored");
    do_write(10'h000, 32'h0BAD_CAFE, -1);
    do_read(10'h020, 1'b1, -1);
    check("intrude_no_wack", 32'(bus.mem_wack), 32'd0);
    do_read(10'h000, 1'b0, -1);

    $display("[TB] reset mid-burst, then re-read");
    do_read(10'h040, 1'b0, 1);
    do_read(10'h040, 1'b0, -1);

    $display("[TB] reset before write commit");
    do_write(10'h010, $urandom, -1);
    do_write(10'h010, 32'hCAFE_F00D, 2);
    for (int k = 0; k < LAT + 2; k++) begin
      step();
      check("abort_no_wack", 32'(bus.mem_wack), 32'd0);
    end
    do_read(10'h010, 1'b0, -1);

    $display("[TB] random traffic");
    for (int n = 0; n < 24; n++) begin
      raddr = 10'($urandom_range(0, 1023));
      if ($urandom_range(0, 1) == 1) do_write(raddr, $urandom, -1);
      else                           do_read(raddr, 1'b0, -1);
    end

`ifdef MAIN_MEM_STATS_EN
    check("rd_count", 32'(rd_count), 32'(exp_rd));
    check("wr_count", 32'(wr_count), 32'(exp_wr));
    pulse_reset("stats_reset");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
